// File: rtl/ht_client.sv
// Client endpoint for the hash table command/result protocol: a credit-limited command
// stage, in-order result checking, per-result-code statistics, and OP_INIT barrier handling.

package ht_pkg;
  localparam int KEY_WIDTH   = 16;
  localparam int VALUE_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_SEARCH = 2'd1,
    OP_INSERT = 2'd2,
    OP_DELETE = 2'd3
  } ht_opcode_e;

  typedef enum logic [2:0] {
    SEARCH_FOUND                     = 3'd0,
    SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
    INSERT_SUCCESS                   = 3'd2,
    INSERT_SUCCESS_SAME_KEY          = 3'd3,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
    DELETE_SUCCESS                   = 3'd5,
    DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6,
    INIT_SUCCESS                     = 3'd7
  } ht_rescode_e;

  typedef struct packed {
    ht_opcode_e             opcode;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;

  typedef struct packed {
    ht_opcode_e             opcode;
    ht_rescode_e            rescode;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_result_t;
endpackage

module ht_client
  import ht_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int STAT_WIDTH      = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  ht_command_t                        req_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  output ht_command_t                        ht_cmd_o,
  output logic                               ht_cmd_valid_o,
  input  logic                               ht_cmd_ready_i,
  input  ht_result_t                         ht_result_i,
  input  logic                               ht_result_valid_i,
  output logic                               ht_result_ready_o,
  output ht_result_t                         rsp_o,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic                               init_busy_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  input  logic                               stat_clr_i,
  output logic [STAT_WIDTH-1:0]              cnt_search_found_o,
  output logic [STAT_WIDTH-1:0]              cnt_search_miss_o,
  output logic [STAT_WIDTH-1:0]              cnt_insert_ok_o,
  output logic [STAT_WIDTH-1:0]              cnt_insert_full_o,
  output logic [STAT_WIDTH-1:0]              cnt_delete_ok_o,
  output logic [STAT_WIDTH-1:0]              cnt_delete_miss_o,
  output logic                               proto_err_o
);

  localparam int             CW        = $clog2(MAX_OUTSTANDING) + 1;
  localparam int             PW        = $clog2(MAX_OUTSTANDING);
  localparam int             NUM_STATS = 6;
  localparam logic [CW-1:0]  MAX_CNT   = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_INIT_WAIT} state_e;

  state_e                 state, state_next;
  ht_command_t            cmd_q;
  logic                   cmd_valid;
  ht_result_t             rsp_q;
  logic                   rsp_valid;
  logic [CW-1:0]          outstanding;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  ht_opcode_e             fifo [MAX_OUTSTANDING];
  logic                   proto_err;
  logic [STAT_WIDTH-1:0]  cnt [NUM_STATS];
  logic [NUM_STATS-1:0]   hit;
  logic                   can_issue, issue, res_acc, pop;

  assign res_acc = ht_result_valid_i && ht_result_ready_o;
  // A result with nothing in flight is an error and must not underflow the credit count.
  assign pop     = res_acc && (outstanding != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_RUN;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    can_issue  = 1'b0;
    if (outstanding != MAX_CNT) begin
      case (state)
        ST_RUN:   can_issue = (req_i.opcode != OP_INIT);
        ST_DRAIN: can_issue = (req_i.opcode == OP_INIT) && (outstanding == '0) && !cmd_valid;
        default:  can_issue = 1'b0;
      endcase
    end
    req_ready_o = (!cmd_valid || ht_cmd_ready_i) && can_issue;
    issue       = req_valid_i && req_ready_o;
    case (state)
      ST_RUN:       if (req_valid_i && req_i.opcode == OP_INIT) state_next = ST_DRAIN;
      ST_DRAIN:     if (issue) state_next = ST_INIT_WAIT;
      ST_INIT_WAIT: if (res_acc && ht_result_i.opcode == OP_INIT) state_next = ST_RUN;
      default:      state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cmd_q       <= '0;
      cmd_valid   <= 1'b0;
      rsp_q       <= '0;
      rsp_valid   <= 1'b0;
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (issue) begin
        cmd_q     <= req_i;
        cmd_valid <= 1'b1;
      end else if (ht_cmd_ready_i) begin
        cmd_valid <= 1'b0;
      end

      if (res_acc) begin
        rsp_q     <= ht_result_i;
        rsp_valid <= 1'b1;
      end else if (rsp_ready_i) begin
        rsp_valid <= 1'b0;
      end

      case ({issue, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (issue) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);

      if (res_acc && ((outstanding == '0) || (ht_result_i.opcode != fifo[rd_ptr])))
        proto_err <= 1'b1;
    end
  end

  // NOTE: the opcode FIFO storage is deliberately not reset; the pointers and credit count define validity.
  always_ff @(posedge clk_i) begin
    if (issue) fifo[wr_ptr] <= req_i.opcode;
  end

  always_comb begin
    hit = '0;
    if (res_acc) begin
      case (ht_result_i.rescode)
        SEARCH_FOUND:                     hit[0] = 1'b1;
        SEARCH_NOT_SUCCESS_NO_ENTRY:      hit[1] = 1'b1;
        INSERT_SUCCESS,
        INSERT_SUCCESS_SAME_KEY:          hit[2] = 1'b1;
        INSERT_NOT_SUCCESS_TABLE_IS_FULL: hit[3] = 1'b1;
        DELETE_SUCCESS:                   hit[4] = 1'b1;
        DELETE_NOT_SUCCESS_NO_ENTRY:      hit[5] = 1'b1;
        default:                          hit = '0;
      endcase
    end
  end

  // Saturating counters; a clear wins over an increment in the same cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_STATS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_STATS; i++) begin
        if (stat_clr_i)                  cnt[i] <= '0;
        else if (hit[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign ht_cmd_o           = cmd_q;
  assign ht_cmd_valid_o     = cmd_valid;
  assign ht_result_ready_o  = !rsp_valid || rsp_ready_i;
  assign rsp_o              = rsp_q;
  assign rsp_valid_o        = rsp_valid;
  assign init_busy_o        = (state == ST_INIT_WAIT);
  assign outstanding_o      = outstanding;
  assign proto_err_o        = proto_err;
  assign cnt_search_found_o = cnt[0];
  assign cnt_search_miss_o  = cnt[1];
  assign cnt_insert_ok_o    = cnt[2];
  assign cnt_insert_full_o  = cnt[3];
  assign cnt_delete_ok_o    = cnt[4];
  assign cnt_delete_miss_o  = cnt[5];

endmodule

// File: tb/tb_ht_client.sv
// Directed self-checking bench for ht_client: reset, credit limit, INIT barrier,
// statistics and saturation, protocol errors, and randomised backpressure.
module tb_ht_client;
  import ht_pkg::*;

  localparam int MAXO = 8;
  localparam int SW   = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  ht_command_t   req;
  logic          req_valid, req_ready;
  ht_command_t   ht_cmd;
  logic          ht_cmd_valid, ht_cmd_ready;
  ht_result_t    ht_result;
  logic          ht_result_valid, ht_result_ready;
  ht_result_t    rsp;
  logic          rsp_valid, rsp_ready;
  logic          init_busy;
  logic [3:0]    outstanding;
  logic          stat_clr;
  logic [SW-1:0] c_sf, c_sm, c_io, c_if, c_do, c_dm;
  logic          proto_err;

  int checks   = 0;
  int failures = 0;

  ht_client #(.MAX_OUTSTANDING(MAXO), .STAT_WIDTH(SW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .ht_cmd_o(ht_cmd), .ht_cmd_valid_o(ht_cmd_valid), .ht_cmd_ready_i(ht_cmd_ready),
    .ht_result_i(ht_result), .ht_result_valid_i(ht_result_valid), .ht_result_ready_o(ht_result_ready),
    .rsp_o(rsp), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .init_busy_o(init_busy), .outstanding_o(outstanding), .stat_clr_i(stat_clr),
    .cnt_search_found_o(c_sf), .cnt_search_miss_o(c_sm), .cnt_insert_ok_o(c_io),
    .cnt_insert_full_o(c_if), .cnt_delete_ok_o(c_do), .cnt_delete_miss_o(c_dm),
    .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ht_command_t mk_cmd(ht_opcode_e op, int k);
    ht_command_t c;
    c.opcode = op;
    c.key    = 16'(k);
    c.value  = 16'(k * 3 + 1);
    return c;
  endfunction

  function automatic ht_result_t mk_res(ht_opcode_e op, ht_rescode_e rc, int k);
    ht_result_t r;
    r.opcode  = op;
    r.rescode = rc;
    r.key     = 16'(k);
    r.value   = 16'(k * 3 + 1);
    return r;
  endfunction

  // Hash table behaviour used by the backpressure scenario.
  function automatic ht_rescode_e pick_rc(ht_opcode_e op, logic [15:0] key);
    case (op)
      OP_SEARCH: return key[0] ? SEARCH_FOUND : SEARCH_NOT_SUCCESS_NO_ENTRY;
      OP_INSERT: return (key % 3 == 0) ? INSERT_SUCCESS :
                        (key % 3 == 1) ? INSERT_SUCCESS_SAME_KEY : INSERT_NOT_SUCCESS_TABLE_IS_FULL;
      OP_DELETE: return key[1] ? DELETE_SUCCESS : DELETE_NOT_SUCCESS_NO_ENTRY;
      default:   return INIT_SUCCESS;
    endcase
  endfunction

  task automatic do_reset();
    rst_i = 1'b0;
    req_valid = 1'b0; req = '0;
    ht_cmd_ready = 1'b1;
    ht_result_valid = 1'b0; ht_result = '0;
    rsp_ready = 1'b1; stat_clr = 1'b0;
    step(); step();
    rst_i = 1'b1;
    step();
  endtask

  task automatic send_req(input ht_command_t c);
    bit ok = 0;
    req = c; req_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (req_ready) begin ok = 1; step(); break; end
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL send_req_timeout: accepted=0 required=1"); end
  endtask

  task automatic send_res(input ht_result_t r);
    bit ok = 0;
    ht_result = r; ht_result_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (ht_result_ready) begin ok = 1; step(); break; end
      step();
    end
    ht_result_valid = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL send_res_timeout: accepted=0 required=1"); end
  endtask

  task automatic pulse_clear();
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_valid = 1'b0; req = '0; ht_cmd_ready = 1'b1;
    ht_result_valid = 1'b0; ht_result = '0; rsp_ready = 1'b1; stat_clr = 1'b0;
    step(); step();
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (ht_result_ready !== 1'b1) begin failures++; $display("FAIL rst_result_ready: got %b want 1", ht_result_ready); end
    checks++; if ({ht_cmd_valid, rsp_valid, init_busy, proto_err} !== 4'b0) begin failures++; $display("FAIL rst_flags: got %b want 0000", {ht_cmd_valid, rsp_valid, init_busy, proto_err}); end
    checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
    checks++; if ({ht_cmd, rsp} !== '0) begin failures++; $display("FAIL rst_data: got cmd=%h rsp=%h want 0", ht_cmd, rsp); end
    checks++; if ({c_sf, c_sm, c_io, c_if, c_do, c_dm} !== '0) begin failures++; $display("FAIL rst_counters: got %h want 0", {c_sf, c_sm, c_io, c_if, c_do, c_dm}); end
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_credit_limit();
    int acc_n = 0;
    bit acc;
    ht_cmd_ready = 1'b1; ht_result_valid = 1'b0;
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 20 && acc_n < 10; cyc++) begin
      req = mk_cmd(OP_SEARCH, acc_n);
      #1; acc = req_ready;
      step();
      if (acc) begin
        acc_n++;
        if (acc_n == 1) begin
          checks++; if (ht_cmd_valid !== 1'b1 || ht_cmd !== mk_cmd(OP_SEARCH, 0)) begin failures++; $display("FAIL credit_first_cmd: got v=%b %h want v=1 %h", ht_cmd_valid, ht_cmd, mk_cmd(OP_SEARCH, 0)); end
        end
      end
    end
    #1;
    checks++; if (acc_n !== 8) begin failures++; $display("FAIL credit_issued: got %0d want 8", acc_n); end
    checks++; if (outstanding !== 4'd8) begin failures++; $display("FAIL credit_outstanding: got %0d want 8", outstanding); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL credit_ready_full: got %b want 0", req_ready); end
    // One result frees a credit, but ready only rises from the registered count a cycle later.
    ht_result = mk_res(OP_SEARCH, SEARCH_FOUND, 0); ht_result_valid = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL credit_ready_same_cycle: got %b want 0", req_ready); end
    step();
    ht_result_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd7) begin failures++; $display("FAIL credit_after_result: got %0d want 7", outstanding); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL credit_ready_next: got %b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    checks++; if (ht_cmd !== mk_cmd(OP_SEARCH, 8) || outstanding !== 4'd8) begin failures++; $display("FAIL credit_ninth: got %h out=%0d want %h out=8", ht_cmd, outstanding, mk_cmd(OP_SEARCH, 8)); end
    for (int k = 1; k <= 8; k++) send_res(mk_res(OP_SEARCH, SEARCH_FOUND, k));
    checks++; if (outstanding !== 4'd0 || proto_err !== 1'b0) begin failures++; $display("FAIL credit_drain: got out=%0d err=%b want 0 0", outstanding, proto_err); end
  endtask

  task automatic test_init_barrier();
    bit early = 0;
    bit ok = 0;
    int wait_n = 0;
    for (int k = 0; k < 3; k++) send_req(mk_cmd(OP_INSERT, 100 + k));
    req = mk_cmd(OP_INIT, 0); req_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin #1; if (req_ready) early = 1; step(); end
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL init_busy_drain: got %b want 0", init_busy); end
    for (int k = 0; k < 3; k++) begin
      ht_result = mk_res(OP_INSERT, INSERT_SUCCESS, 100 + k); ht_result_valid = 1'b1;
      #1; if (req_ready) early = 1;
      step();
    end
    ht_result_valid = 1'b0;
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL init_early_issue: got %b want 0", early); end
    for (int n = 0; n < 10; n++) begin
      #1;
      if (req_ready) begin ok = 1; step(); break; end
      wait_n++; step();
    end
    checks++; if (!ok || wait_n !== 0) begin failures++; $display("FAIL init_issue: got ok=%b wait=%0d want ok=1 wait=0", ok, wait_n); end
    checks++; if (init_busy !== 1'b1 || ht_cmd_valid !== 1'b1 || ht_cmd.opcode !== OP_INIT) begin failures++; $display("FAIL init_issued_state: got busy=%b v=%b op=%0d want 1 1 0", init_busy, ht_cmd_valid, ht_cmd.opcode); end
    req = mk_cmd(OP_SEARCH, 55); early = 0;
    for (int n = 0; n < 3; n++) begin #1; if (req_ready) early = 1; step(); end
    checks++; if (early !== 1'b0 || init_busy !== 1'b1) begin failures++; $display("FAIL init_wait_block: got early=%b busy=%b want 0 1", early, init_busy); end
    ht_result = mk_res(OP_INIT, INIT_SUCCESS, 0); ht_result_valid = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL init_result_cycle_ready: got %b want 0", req_ready); end
    step();
    ht_result_valid = 1'b0;
    #1;
    checks++; if (init_busy !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL init_release: got busy=%b ready=%b want 0 1", init_busy, req_ready); end
    step();
    req_valid = 1'b0;
    checks++; if (outstanding !== 4'd1 || ht_cmd !== mk_cmd(OP_SEARCH, 55)) begin failures++; $display("FAIL init_following_search: got out=%0d %h want 1 %h", outstanding, ht_cmd, mk_cmd(OP_SEARCH, 55)); end
    send_res(mk_res(OP_SEARCH, SEARCH_FOUND, 55));
  endtask

  task automatic test_statistics();
    ht_opcode_e  ops [5] = '{OP_SEARCH, OP_SEARCH, OP_INSERT, OP_INSERT, OP_DELETE};
    ht_rescode_e rcs [5] = '{SEARCH_FOUND, SEARCH_FOUND, INSERT_SUCCESS_SAME_KEY,
                             INSERT_NOT_SUCCESS_TABLE_IS_FULL, DELETE_NOT_SUCCESS_NO_ENTRY};
    pulse_clear();
    checks++; if ({c_sf, c_sm, c_io, c_if, c_do, c_dm} !== '0) begin failures++; $display("FAIL stat_clear: got %h want 0", {c_sf, c_sm, c_io, c_if, c_do, c_dm}); end
    for (int i = 0; i < 5; i++) begin
      send_req(mk_cmd(ops[i], 300 + i));
      send_res(mk_res(ops[i], rcs[i], 300 + i));
    end
    checks++; if (c_sf !== 4'd2) begin failures++; $display("FAIL stat_search_found: got %0d want 2", c_sf); end
    checks++; if (c_sm !== 4'd0) begin failures++; $display("FAIL stat_search_miss: got %0d want 0", c_sm); end
    checks++; if (c_io !== 4'd1) begin failures++; $display("FAIL stat_insert_ok: got %0d want 1", c_io); end
    checks++; if (c_if !== 4'd1) begin failures++; $display("FAIL stat_insert_full: got %0d want 1", c_if); end
    checks++; if (c_do !== 4'd0) begin failures++; $display("FAIL stat_delete_ok: got %0d want 0", c_do); end
    checks++; if (c_dm !== 4'd1) begin failures++; $display("FAIL stat_delete_miss: got %0d want 1", c_dm); end
    send_req(mk_cmd(OP_SEARCH, 310));
    ht_result = mk_res(OP_SEARCH, SEARCH_FOUND, 310); ht_result_valid = 1'b1; stat_clr = 1'b1;
    step();
    ht_result_valid = 1'b0; stat_clr = 1'b0;
    checks++; if ({c_sf, c_sm, c_io, c_if, c_do, c_dm} !== '0) begin failures++; $display("FAIL stat_clear_priority: got %h want 0", {c_sf, c_sm, c_io, c_if, c_do, c_dm}); end
    checks++; if (rsp_valid !== 1'b1 || rsp !== mk_res(OP_SEARCH, SEARCH_FOUND, 310)) begin failures++; $display("FAIL stat_rsp_forward: got v=%b %h want v=1 %h", rsp_valid, rsp, mk_res(OP_SEARCH, SEARCH_FOUND, 310)); end
  endtask

  task automatic test_saturation();
    pulse_clear();
    for (int i = 0; i < 20; i++) begin
      send_req(mk_cmd(OP_SEARCH, 400 + i));
      send_res(mk_res(OP_SEARCH, SEARCH_FOUND, 400 + i));
    end
    checks++; if (c_sf !== 4'd15) begin failures++; $display("FAIL sat_search_found: got %0d want 15", c_sf); end
    checks++; if (c_io !== 4'd0) begin failures++; $display("FAIL sat_other_counter: got %0d want 0", c_io); end
  endtask

  task automatic test_proto_err();
    do_reset();
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL perr_initial: got %b want 0", proto_err); end
    ht_result = mk_res(OP_SEARCH, SEARCH_FOUND, 7); ht_result_valid = 1'b1;
    step();
    ht_result_valid = 1'b0;
    checks++; if (proto_err !== 1'b1 || outstanding !== 4'd0) begin failures++; $display("FAIL perr_no_outstanding: got err=%b out=%0d want 1 0", proto_err, outstanding); end
    checks++; if (rsp_valid !== 1'b1 || rsp !== mk_res(OP_SEARCH, SEARCH_FOUND, 7)) begin failures++; $display("FAIL perr_forwarded: got v=%b %h want v=1 %h", rsp_valid, rsp, mk_res(OP_SEARCH, SEARCH_FOUND, 7)); end
    step(); step(); step();
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL perr_sticky: got %b want 1", proto_err); end
    do_reset();
    send_req(mk_cmd(OP_SEARCH, 1));
    send_req(mk_cmd(OP_SEARCH, 2));
    checks++; if (outstanding !== 4'd2) begin failures++; $display("FAIL midrst_before: got %0d want 2", outstanding); end
    do_reset();
    checks++; if (outstanding !== 4'd0 || proto_err !== 1'b0 || ht_cmd_valid !== 1'b0) begin failures++; $display("FAIL midrst_after: got out=%0d err=%b v=%b want 0 0 0", outstanding, proto_err, ht_cmd_valid); end
    send_res(mk_res(OP_SEARCH, SEARCH_FOUND, 1));
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL midrst_late_result: got %b want 1", proto_err); end
    do_reset();
    send_req(mk_cmd(OP_SEARCH, 9));
    send_res(mk_res(OP_DELETE, DELETE_SUCCESS, 9));
    checks++; if (proto_err !== 1'b1 || outstanding !== 4'd0) begin failures++; $display("FAIL perr_opcode: got err=%b out=%0d want 1 0", proto_err, outstanding); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    ht_command_t reqs [100];
    ht_result_t  pend [$];
    ht_result_t  r, want, stall_rsp;
    int ri = 0, ci = 0, oi = 0;
    bit stall_prev = 0;
    bit req_acc, cmd_acc, res_acc;
    for (int i = 0; i < 100; i++) reqs[i] = mk_cmd(ht_opcode_e'((i % 3) + 1), 200 + i);
    for (int cyc = 0; cyc < 5000 && oi < 100; cyc++) begin
      req_valid = (ri < 100);
      if (ri < 100) req = reqs[ri];
      ht_cmd_ready = ($urandom_range(0, 3) != 0);
      ht_result_valid = (pend.size() > 0);
      if (pend.size() > 0) ht_result = pend[0];
      rsp_ready = $urandom_range(0, 1) == 1;
      #1;
      if (stall_prev) begin
        checks++; if (rsp_valid !== 1'b1 || rsp !== stall_rsp) begin failures++; $display("FAIL b2b_rsp_hold: got v=%b %h want v=1 %h", rsp_valid, rsp, stall_rsp); end
      end
      req_acc = req_valid && req_ready;
      cmd_acc = ht_cmd_valid && ht_cmd_ready;
      res_acc = ht_result_valid && ht_result_ready;
      if (cmd_acc) begin
        checks++; if (ht_cmd !== reqs[ci]) begin failures++; $display("FAIL b2b_cmd[%0d]: got %h want %h", ci, ht_cmd, reqs[ci]); end
        r.opcode = ht_cmd.opcode; r.rescode = pick_rc(ht_cmd.opcode, ht_cmd.key);
        r.key = ht_cmd.key; r.value = ht_cmd.value;
        pend.push_back(r);
        ci++;
      end
      if (rsp_valid && rsp_ready) begin
        want.opcode = reqs[oi].opcode; want.rescode = pick_rc(reqs[oi].opcode, reqs[oi].key);
        want.key = reqs[oi].key; want.value = reqs[oi].value;
        checks++; if (rsp !== want) begin failures++; $display("FAIL b2b_rsp[%0d]: got %h want %h", oi, rsp, want); end
        oi++;
      end
      stall_prev = rsp_valid && !rsp_ready;
      stall_rsp  = rsp;
      if (req_acc) ri++;
      step();
      if (res_acc) void'(pend.pop_front());
    end
    req_valid = 1'b0; ht_result_valid = 1'b0; rsp_ready = 1'b1; ht_cmd_ready = 1'b1;
    checks++; if (oi !== 100) begin failures++; $display("FAIL b2b_delivered: got %0d want 100", oi); end
    checks++; if (proto_err !== 1'b0 || outstanding !== 4'd0) begin failures++; $display("FAIL b2b_final: got err=%b out=%0d want 0 0", proto_err, outstanding); end
  endtask

  initial begin
    test_reset();
    test_credit_limit();
    test_init_barrier();
    test_statistics();
    test_saturation();
    test_proto_err();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ht_client.md
# ht_client

Client-side endpoint for the hash table command/result protocol; it sits between a request source and the hash table core. It accepts `ht_command_t` requests, forwards them as a flow-controlled command stream, and limits in-flight commands to a credit budget. It collects `ht_result_t` results in order, checks each against the opcode that was issued, and keeps per-result-code statistics. `OP_INIT` acts as a barrier: the pipeline is drained before the init is issued, and nothing follows it until its result returns.

## Interface
- `MAX_OUTSTANDING`, 8, max commands issued but not yet answered (power of two, 2..64)
- `STAT_WIDTH`, 16, width of each statistics counter
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; asynchronous, active-low
- `req_i`  in  `$bits(ht_command_t)`  request from upstream
- `req_valid_i` / `req_ready_o`  in / out  1  upstream handshake
- `ht_cmd_o`  out  `$bits(ht_command_t)`  command to hash table
- `ht_cmd_valid_o` / `ht_cmd_ready_i`  out / in  1  command handshake
- `ht_result_i`  in  `$bits(ht_result_t)`  result from hash table
- `ht_result_valid_i` / `ht_result_ready_o`  in / out  1  result handshake
- `rsp_o`  out  `$bits(ht_result_t)`  result to downstream
- `rsp_valid_o` / `rsp_ready_i`  out / in  1  downstream handshake
- `init_busy_o`  out  1  high from `OP_INIT` acceptance until its result is accepted
- `outstanding_o`  out  `$clog2(MAX_OUTSTANDING)+1`  in-flight command count
- `stat_clr_i`  in  1  synchronous clear of all statistics counters
- `cnt_search_found_o`, `cnt_search_miss_o`, `cnt_insert_ok_o`, `cnt_insert_full_o`, `cnt_delete_ok_o`, `cnt_delete_miss_o`  out  `STAT_WIDTH` each  result counters
- `proto_err_o`  out  1  sticky protocol error

## Operation
- **Command stage**
  - One-register stage drives `ht_cmd_o`.
  - `req_ready_o = (!ht_cmd_valid_o || ht_cmd_ready_i) && can_issue`.
  - A command is issued when it is accepted on the upstream handshake. At that point, `outstanding` increments and the command's opcode is pushed into the opcode FIFO (depth `MAX_OUTSTANDING`).
- **can_issue**
  - True only when `outstanding < MAX_OUTSTANDING` and the FSM permits the request's opcode.
- **FSM**
  - RUN:
    - Non-INIT requests issue normally.
    - An `OP_INIT` at `req_i` holds `req_ready_o` low and moves the FSM to DRAIN.
  - DRAIN:
    - Nothing is issued.
    - When `outstanding == 0` and the command register is empty, the INIT is accepted, `init_busy_o` is set, and the FSM moves to INIT_WAIT.
  - INIT_WAIT:
    - Nothing is issued.
    - When a result with opcode `OP_INIT` is accepted, `init_busy_o` clears and the FSM returns to RUN.
- **Result stage**
  - `ht_result_ready_o = !rsp_valid_o || rsp_ready_i`.
  - Each accepted result loads `rsp_o` unchanged, pops the opcode FIFO, and decrements `outstanding`.
  - Issue and result in the same cycle leave `outstanding` unchanged.
- **Protocol check**
  - `proto_err_o` is set if a result arrives while `outstanding == 0`.
  - `proto_err_o` is also set if the result opcode differs from the popped FIFO opcode.
  - The flag is sticky until reset. Results are forwarded regardless of the flag.
- **Statistics**
  - On result acceptance, the counter matching the rescode increments:
    - `SEARCH_FOUND` → search_found
    - `SEARCH_NOT_SUCCESS_NO_ENTRY` → search_miss
    - `INSERT_SUCCESS` and `INSERT_SUCCESS_SAME_KEY` → insert_ok
    - `INSERT_NOT_SUCCESS_TABLE_IS_FULL` → insert_full
    - `DELETE_SUCCESS` → delete_ok
    - `DELETE_NOT_SUCCESS_NO_ENTRY` → delete_miss
  - `INIT_SUCCESS` is not counted.
  - Counters saturate at all-ones.
  - `stat_clr_i` has priority over a same-cycle increment.

## Timing
- **Reset values:** all valids 0, data outputs 0, `req_ready_o` 0, `ht_result_ready_o` 1 (no response pending), `init_busy_o` 0, `outstanding_o` 0, all counters 0, `proto_err_o` 0, FSM RUN.
- **Reset mid-operation:** in-flight state is dropped, the FIFO is emptied, and the FSM goes to RUN. Results returning after reset set `proto_err_o`.
- **Latency:**
  - Request accept → `ht_cmd_valid_o` in the next cycle.
  - Result accept → `rsp_valid_o` in the next cycle.
- **Throughput:** one command and one result per cycle, with no bubbles under continuous ready.
- **Handshakes:** valid and data hold stable while valid is high and ready is low. Ready may depend combinationally on downstream ready.
- **Full condition:** at `outstanding == MAX_OUTSTANDING`, `req_ready_o` is 0. If a result is accepted in the same cycle, `req_ready_o` still waits one cycle, since it uses the registered count.
- **Statistics timing:** counters update in the cycle after result acceptance.

## Test plan
- **Credit limit:** reset, MAX_OUTSTANDING=8, ht_result_valid_i held 0, send 10 SEARCH requests → exactly 8 issued, `outstanding_o`=8, `req_ready_o`=0. Then return 1 result → a 9th is issued two cycles later.
- **INIT barrier:** 3 INSERTs in flight, then INIT → INIT not issued until the 3 results return. `init_busy_o`=1 until the INIT_SUCCESS result; a following SEARCH is issued only afterwards.
- **Statistics:** results 2×SEARCH_FOUND, 1×INSERT_SUCCESS_SAME_KEY, 1×INSERT_NOT_SUCCESS_TABLE_IS_FULL, 1×DELETE_NOT_SUCCESS_NO_ENTRY → counters read 2, 0, 1, 1, 0, 1. Pulse `stat_clr_i` in the same cycle as a result → all counters 0.
- **Saturation:** STAT_WIDTH=4, 20 SEARCH_FOUND results → `cnt_search_found_o`=15.
- **Protocol error:** inject a result with `outstanding_o`=0 → `proto_err_o`=1 next cycle and it stays set. Separately, issue SEARCH and return a DELETE result → `proto_err_o`=1.
- **Backpressure:** `rsp_ready_i` toggled randomly with 100 mixed commands → all 100 results delivered in order, none lost, `rsp_o` stable while stalled.
